// File: rtl/rt_frame_sequencer.sv
// Top-level ray-tracing frame sequencer: loads objects and camera, then per pixel issues a ray,
// streams the object list to the RTU, captures the colour and writes it to the frame buffer.
module rt_frame_sequencer #(
    parameter int unsigned H_RES    = 320,
    parameter int unsigned V_RES    = 240,
    parameter int unsigned MAX_OBJS = 64,
    parameter int unsigned COLOR_W  = 12,
    localparam int unsigned X_W     = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int unsigned Y_W     = (V_RES > 1) ? $clog2(V_RES) : 1,
    localparam int unsigned OBJ_W   = (MAX_OBJS > 1) ? $clog2(MAX_OBJS) : 1,
    localparam int unsigned NOBJ_W  = $clog2(MAX_OBJS + 1),
    localparam int unsigned FB_AW   = (H_RES * V_RES > 1) ? $clog2(H_RES * V_RES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               continuous,
    input  logic               abort,
    input  logic [NOBJ_W-1:0]  num_objs,
    output logic               objs_load_req,
    input  logic               objs_load_done,
    output logic               cam_load_req,
    input  logic               cam_load_done,
    output logic               ray_valid,
    input  logic               ray_ready,
    output logic [X_W-1:0]     ray_x,
    output logic [Y_W-1:0]     ray_y,
    output logic               ray_no_objs,
    output logic               obj_valid,
    input  logic               obj_ready,
    output logic [OBJ_W-1:0]   obj_idx,
    output logic               obj_last,
    input  logic               rtu_valid,
    output logic               rtu_ready,
    input  logic [COLOR_W-1:0] rtu_color,
    output logic               fb_we,
    input  logic               fb_ready,
    output logic [FB_AW-1:0]   fb_addr,
    output logic [COLOR_W-1:0] fb_wdata,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        frame_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadObjs,
        StLoadCam,
        StCamToRtu,
        StObjToRtu,
        StRtuWait,
        StRtuToFb,
        StFrameDone
    } state_e;

    state_e             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [FB_AW-1:0]   fb_addr_q, fb_addr_d;
    logic [OBJ_W-1:0]   obj_idx_q, obj_idx_d;
    logic [NOBJ_W-1:0]  num_objs_q, num_objs_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               abort_pend_q, abort_pend_d;

    logic objs_load_req_q, objs_load_req_d;
    logic cam_load_req_q, cam_load_req_d;
    logic ray_valid_q, ray_valid_d;
    logic ray_no_objs_q, ray_no_objs_d;
    logic obj_valid_q, obj_valid_d;
    logic obj_last_q, obj_last_d;
    logic rtu_ready_q, rtu_ready_d;
    logic fb_we_q, fb_we_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;

    logic abort_any;
    logic last_col;
    logic last_row;
    logic last_pixel;

    // A pending abort or one arriving this cycle both count at a pixel boundary.
    assign abort_any  = abort | abort_pend_q;
    assign last_col   = (x_q == X_W'(H_RES - 1));
    assign last_row   = (y_q == Y_W'(V_RES - 1));
    assign last_pixel = last_col & last_row;

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        fb_addr_d     = fb_addr_q;
        obj_idx_d     = obj_idx_q;
        num_objs_d    = num_objs_q;
        color_d       = color_q;
        frame_count_d = frame_count_q;
        abort_pend_d  = abort_pend_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    num_objs_d = (num_objs > NOBJ_W'(MAX_OBJS)) ? NOBJ_W'(MAX_OBJS) : num_objs;
                    state_d    = StLoadObjs;
                end
            end
            StLoadObjs: begin
                if (abort_any) begin
                    state_d = StIdle;
                end else if (objs_load_done) begin
                    state_d = StLoadCam;
                end
            end
            StLoadCam: begin
                if (abort_any) begin
                    state_d = StIdle;
                end else if (cam_load_done) begin
                    state_d = StCamToRtu;
                end
            end
            StCamToRtu: begin
                if (ray_valid_q && ray_ready) begin
                    state_d = (num_objs_q == '0) ? StRtuWait : StObjToRtu;
                end
            end
            StObjToRtu: begin
                if (obj_valid_q && obj_ready) begin
                    if (obj_last_q) begin
                        state_d = StRtuWait;
                    end else begin
                        obj_idx_d = obj_idx_q + OBJ_W'(1);
                    end
                end
            end
            StRtuWait: begin
                if (rtu_valid && rtu_ready_q) begin
                    color_d = rtu_color;
                    state_d = StRtuToFb;
                end
            end
            StRtuToFb: begin
                if (fb_we_q && fb_ready) begin
                    fb_addr_d = fb_addr_q + FB_AW'(1);
                    if (last_col) begin
                        x_d = '0;
                        y_d = last_row ? '0 : y_q + Y_W'(1);
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                    if (abort_any) begin
                        state_d = StIdle;
                    end else if (last_pixel) begin
                        state_d       = StFrameDone;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        state_d = StCamToRtu;
                    end
                end
            end
            StFrameDone: begin
                state_d = continuous ? StLoadCam : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StLoadCam && state_q != StLoadCam) begin
            x_d       = '0;
            y_d       = '0;
            fb_addr_d = '0;
        end
        if (state_d == StCamToRtu && state_q != StCamToRtu) begin
            obj_idx_d = '0;
        end

        if (state_d == StIdle) begin
            abort_pend_d = 1'b0;
        end else if (abort && state_q != StIdle) begin
            abort_pend_d = 1'b1;
        end

        // Outputs are registered and decoded from the next state so they rise on state entry.
        objs_load_req_d = (state_d == StLoadObjs);
        cam_load_req_d  = (state_d == StLoadCam);
        ray_valid_d     = (state_d == StCamToRtu);
        obj_valid_d     = (state_d == StObjToRtu);
        rtu_ready_d     = (state_d == StRtuWait);
        fb_we_d         = (state_d == StRtuToFb);
        frame_done_d    = (state_d == StFrameDone);
        busy_d          = (state_d != StIdle);
        ray_no_objs_d   = busy_d && (num_objs_d == '0);
        obj_last_d      = (state_d == StObjToRtu) &&
                          (NOBJ_W'(obj_idx_d) == num_objs_d - NOBJ_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            x_q             <= '0;
            y_q             <= '0;
            fb_addr_q       <= '0;
            obj_idx_q       <= '0;
            num_objs_q      <= '0;
            color_q         <= '0;
            frame_count_q   <= '0;
            abort_pend_q    <= 1'b0;
            objs_load_req_q <= 1'b0;
            cam_load_req_q  <= 1'b0;
            ray_valid_q     <= 1'b0;
            ray_no_objs_q   <= 1'b0;
            obj_valid_q     <= 1'b0;
            obj_last_q      <= 1'b0;
            rtu_ready_q     <= 1'b0;
            fb_we_q         <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            x_q             <= x_d;
            y_q             <= y_d;
            fb_addr_q       <= fb_addr_d;
            obj_idx_q       <= obj_idx_d;
            num_objs_q      <= num_objs_d;
            color_q         <= color_d;
            frame_count_q   <= frame_count_d;
            abort_pend_q    <= abort_pend_d;
            objs_load_req_q <= objs_load_req_d;
            cam_load_req_q  <= cam_load_req_d;
            ray_valid_q     <= ray_valid_d;
            ray_no_objs_q   <= ray_no_objs_d;
            obj_valid_q     <= obj_valid_d;
            obj_last_q      <= obj_last_d;
            rtu_ready_q     <= rtu_ready_d;
            fb_we_q         <= fb_we_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign objs_load_req = objs_load_req_q;
    assign cam_load_req  = cam_load_req_q;
    assign ray_valid     = ray_valid_q;
    assign ray_x         = x_q;
    assign ray_y         = y_q;
    assign ray_no_objs   = ray_no_objs_q;
    assign obj_valid     = obj_valid_q;
    assign obj_idx       = obj_idx_q;
    assign obj_last      = obj_last_q;
    assign rtu_ready     = rtu_ready_q;
    assign fb_we         = fb_we_q;
    assign fb_addr       = fb_addr_q;
    assign fb_wdata      = color_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_rt_frame_sequencer.sv
// Scoreboard bench for rt_frame_sequencer: a pixel-level model queues expected rays, object beats
// and frame-buffer writes; a monitor pops and compares them on every handshake.
module tb_rt_frame_sequencer;

    localparam int H      = 4;
    localparam int V      = 2;
    localparam int MAXO   = 4;
    localparam int CW     = 12;
    localparam int X_W    = 2;
    localparam int Y_W    = 1;
    localparam int OBJ_W  = 2;
    localparam int NOBJ_W = 3;
    localparam int FB_AW  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic              abort = 1'b0;
    logic [NOBJ_W-1:0] num_objs = '0;
    logic              objs_load_done = 1'b0;
    logic              cam_load_done = 1'b0;
    logic              ray_ready = 1'b0;
    logic              obj_ready = 1'b0;
    logic              rtu_valid = 1'b0;
    logic [CW-1:0]     rtu_color = '0;
    logic              fb_ready = 1'b0;
    logic              objs_load_req, cam_load_req, ray_valid, ray_no_objs;
    logic              obj_valid, obj_last, rtu_ready, fb_we, busy, frame_done;
    logic [X_W-1:0]    ray_x;
    logic [Y_W-1:0]    ray_y;
    logic [OBJ_W-1:0]  obj_idx;
    logic [FB_AW-1:0]  fb_addr;
    logic [CW-1:0]     fb_wdata;
    logic [15:0]       frame_count;

    rt_frame_sequencer #(
        .H_RES   (H),
        .V_RES   (V),
        .MAX_OBJS(MAXO),
        .COLOR_W (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .continuous    (continuous),
        .abort         (abort),
        .num_objs      (num_objs),
        .objs_load_req (objs_load_req),
        .objs_load_done(objs_load_done),
        .cam_load_req  (cam_load_req),
        .cam_load_done (cam_load_done),
        .ray_valid     (ray_valid),
        .ray_ready     (ray_ready),
        .ray_x         (ray_x),
        .ray_y         (ray_y),
        .ray_no_objs   (ray_no_objs),
        .obj_valid     (obj_valid),
        .obj_ready     (obj_ready),
        .obj_idx       (obj_idx),
        .obj_last      (obj_last),
        .rtu_valid     (rtu_valid),
        .rtu_ready     (rtu_ready),
        .rtu_color     (rtu_color),
        .fb_we         (fb_we),
        .fb_ready      (fb_ready),
        .fb_addr       (fb_addr),
        .fb_wdata      (fb_wdata),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_count   (frame_count)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    typedef struct { int x; int y; int no; } ray_t;
    typedef struct { int idx; int last; } obj_t;
    typedef struct { int addr; int data; } fb_t;

    ray_t exp_ray[$];
    obj_t exp_obj[$];
    fb_t  exp_fb[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int fd_cnt = 0, olr_rises = 0, clr_rises = 0, fb_cnt = 0, ov_cycles = 0;
    int lat_n = -1, last_fb_cyc = -1;
    int salt = 0, obj_stall = 0, fb_hold = 0;
    bit rnd_mode = 1'b0;

    task automatic chk_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int color_of(input int x, input int y);
        return ((x + y * H) ^ salt) & 'hfff;
    endfunction

    // Expected traffic for pixels 0..last_p of one frame with n requested objects.
    task automatic push_frame(input int n, input int last_p);
        int ne;
        ne = (n > MAXO) ? MAXO : n;
        for (int p = 0; p <= last_p; p++) begin
            ray_t r;
            fb_t  f;
            r.x  = p % H;
            r.y  = p / H;
            r.no = (ne == 0) ? 1 : 0;
            exp_ray.push_back(r);
            for (int i = 0; i < ne; i++) begin
                obj_t o;
                o.idx  = i;
                o.last = (i == ne - 1) ? 1 : 0;
                exp_obj.push_back(o);
            end
            f.addr = p;
            f.data = color_of(p % H, p / H);
            exp_fb.push_back(f);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk_eq("rst_ctrl_outputs", int'({objs_load_req, cam_load_req, ray_valid, ray_no_objs,
               obj_valid, obj_last, rtu_ready, fb_we, busy, frame_done}), 0);
        chk_eq("rst_ray_xy", int'({ray_x, ray_y}), 0);
        chk_eq("rst_obj_idx", int'(obj_idx), 0);
        chk_eq("rst_fb_addr", int'(fb_addr), 0);
        chk_eq("rst_fb_wdata", int'(fb_wdata), 0);
        chk_eq("rst_frame_count", int'(frame_count), 0);
        @(negedge clk);
        exp_ray.delete();
        exp_obj.delete();
        exp_fb.delete();
        fd_cnt = 0; olr_rises = 0; clr_rises = 0; fb_cnt = 0; ov_cycles = 0;
        last_fb_cyc = -1; lat_n = -1; obj_stall = 0; fb_hold = 0;
        continuous = 1'b0;
        abort = 1'b0;
        rst = 1'b0;
    endtask

    task automatic start_frame(input int n);
        @(negedge clk);
        num_objs = NOBJ_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd(input int target, input int budget);
        int k = 0;
        while (fd_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk_eq("frame_done_count", fd_cnt, target);
    endtask

    task automatic end_checks(input int fc, input int fd);
        idle(12);
        chk_eq("busy_after", int'(busy), 0);
        chk_eq("frame_count", int'(frame_count), fc);
        chk_eq("frame_done_pulses", fd_cnt, fd);
        chk_eq("ray_left", exp_ray.size(), 0);
        chk_eq("obj_left", exp_obj.size(), 0);
        chk_eq("fb_left", exp_fb.size(), 0);
    endtask

    // Ready/done driver, applied just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) begin
                ray_ready      = ($urandom_range(0, 3) != 0);
                obj_ready      = ($urandom_range(0, 2) != 0);
                rtu_valid      = ($urandom_range(0, 3) == 0);
                fb_ready       = ($urandom_range(0, 1) != 0);
                objs_load_done = ($urandom_range(0, 2) == 0);
                cam_load_done  = ($urandom_range(0, 2) == 0);
            end else begin
                ray_ready      = 1'b1;
                obj_ready      = 1'b1;
                rtu_valid      = 1'b1;
                fb_ready       = 1'b1;
                objs_load_done = 1'b1;
                cam_load_done  = 1'b1;
            end
            if (obj_stall > 0 && obj_valid) begin
                obj_ready = 1'b0;
                obj_stall--;
            end
            if (fb_hold > 0 && fb_we) begin
                fb_ready = 1'b0;
                fb_hold--;
            end
        end
    end

    // RTU stand-in: the colour follows the most recently accepted ray.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ray_valid && ray_ready) rtu_color = CW'(color_of(int'(ray_x), int'(ray_y)));
        end
    end

    logic             pv_rv, pv_rr, pv_ov, pv_or, pv_fw, pv_fr, pv_olr, pv_clr, pv_ol;
    logic [X_W-1:0]   pv_rx;
    logic [Y_W-1:0]   pv_ry;
    logic [OBJ_W-1:0] pv_oi;
    logic [FB_AW-1:0] pv_fa;
    logic [CW-1:0]    pv_fd;
    ray_t             m_r;
    obj_t             m_o;
    fb_t              m_f;

    initial begin
        {pv_rv, pv_rr, pv_ov, pv_or, pv_fw, pv_fr, pv_olr, pv_clr, pv_ol} = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                {pv_rv, pv_ov, pv_fw, pv_olr, pv_clr} = '0;
            end else begin
                if (pv_rv && !pv_rr) begin
                    chk_eq("ray_valid_held", int'(ray_valid), 1);
                    chk_eq("ray_xy_stable", int'({ray_x, ray_y}), int'({pv_rx, pv_ry}));
                end
                if (ray_valid && ray_ready) begin
                    chk_eq("ray_expected", int'(exp_ray.size() > 0), 1);
                    if (exp_ray.size() > 0) begin
                        m_r = exp_ray.pop_front();
                        chk_eq("ray_x", int'(ray_x), m_r.x);
                        chk_eq("ray_y", int'(ray_y), m_r.y);
                        chk_eq("ray_no_objs", int'(ray_no_objs), m_r.no);
                    end
                end
                if (pv_ov && !pv_or) begin
                    chk_eq("obj_valid_held", int'(obj_valid), 1);
                    chk_eq("obj_idx_stable", int'(obj_idx), int'(pv_oi));
                    chk_eq("obj_last_stable", int'(obj_last), int'(pv_ol));
                end
                if (obj_valid) ov_cycles++;
                if (obj_valid && obj_ready) begin
                    chk_eq("obj_expected", int'(exp_obj.size() > 0), 1);
                    if (exp_obj.size() > 0) begin
                        m_o = exp_obj.pop_front();
                        chk_eq("obj_idx", int'(obj_idx), m_o.idx);
                        chk_eq("obj_last", int'(obj_last), m_o.last);
                    end
                end
                if (pv_fw && !pv_fr) begin
                    chk_eq("fb_we_held", int'(fb_we), 1);
                    chk_eq("fb_addr_stable", int'(fb_addr), int'(pv_fa));
                    chk_eq("fb_wdata_stable", int'(fb_wdata), int'(pv_fd));
                end
                if (fb_we && fb_ready) begin
                    fb_cnt++;
                    chk_eq("fb_expected", int'(exp_fb.size() > 0), 1);
                    if (exp_fb.size() > 0) begin
                        m_f = exp_fb.pop_front();
                        chk_eq("fb_addr", int'(fb_addr), m_f.addr);
                        chk_eq("fb_wdata", int'(fb_wdata), m_f.data);
                    end
                    if (lat_n >= 0 && last_fb_cyc >= 0) chk_eq("pixel_latency", cyc - last_fb_cyc, lat_n);
                    last_fb_cyc = cyc;
                end
                if (frame_done) fd_cnt++;
                if (objs_load_req && !pv_olr) olr_rises++;
                if (cam_load_req && !pv_clr) clr_rises++;
                pv_rv = ray_valid; pv_rr = ray_ready; pv_rx = ray_x; pv_ry = ray_y;
                pv_ov = obj_valid; pv_or = obj_ready; pv_oi = obj_idx; pv_ol = obj_last;
                pv_fw = fb_we; pv_fr = fb_ready; pv_fa = fb_addr; pv_fd = fb_wdata;
                pv_olr = objs_load_req; pv_clr = cam_load_req;
            end
        end
    end

    initial begin
        int n;
        int k;

        // Basic frame, everything ready: data equals pixel index, N+3 cycles per pixel.
        do_reset();
        salt = 0;
        lat_n = 6;
        push_frame(3, H * V - 1);
        start_frame(3);
        wait_fd(1, 600);
        chk_eq("fb_writes", fb_cnt, 8);
        chk_eq("objs_load_once", olr_rises, 1);
        end_checks(1, 1);

        // Randomised handshakes with a forced obj_ready stall mid-stream.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            salt = int'($urandom_range(0, 4095));
            n = int'($urandom_range(2, 4));
            rnd_mode = 1'b1;
            push_frame(n, H * V - 1);
            start_frame(n);
            k = 0;
            while (!(obj_valid && obj_idx == OBJ_W'(1)) && k < 400) begin
                @(negedge clk);
                k++;
            end
            chk_eq("stall_point_reached", int'(obj_valid && obj_idx == OBJ_W'(1)), 1);
            obj_stall = 5;
            idle(20);
            if (busy) start_frame(1);
            wait_fd(1, 4000);
            rnd_mode = 1'b0;
            end_checks(1, 1);
        end

        // Zero objects: no object beats at all.
        do_reset();
        salt = 0;
        lat_n = 3;
        push_frame(0, H * V - 1);
        start_frame(0);
        wait_fd(1, 400);
        chk_eq("no_obj_valid", ov_cycles, 0);
        chk_eq("fb_writes_n0", fb_cnt, 8);
        end_checks(1, 1);

        // Oversized object count clamps to MAX_OBJS.
        do_reset();
        salt = int'($urandom_range(0, 4095));
        push_frame(7, H * V - 1);
        start_frame(7);
        wait_fd(1, 600);
        end_checks(1, 1);

        // Continuous mode over three frames; objects loaded only once.
        do_reset();
        salt = 5;
        push_frame(1, H * V - 1);
        push_frame(1, H * V - 1);
        push_frame(1, H * V - 1);
        continuous = 1'b1;
        start_frame(1);
        wait_fd(2, 600);
        idle(3);
        continuous = 1'b0;
        wait_fd(3, 600);
        chk_eq("objs_load_req_rises", olr_rises, 1);
        chk_eq("cam_load_req_rises", clr_rises, 3);
        end_checks(3, 3);

        // Abort during a stalled write of pixel 5.
        do_reset();
        salt = 0;
        push_frame(2, 5);
        start_frame(2);
        k = 0;
        while (!(ray_valid && ray_x == X_W'(1) && ray_y == Y_W'(1)) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk_eq("pixel5_ray_seen", int'(ray_valid && ray_x == X_W'(1) && ray_y == Y_W'(1)), 1);
        fb_hold = 3;
        k = 0;
        while (!(fb_we && fb_addr == FB_AW'(5)) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk_eq("pixel5_write_seen", int'(fb_we && fb_addr == FB_AW'(5)), 1);
        chk_eq("pixel5_stalled", int'(fb_ready), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        idle(10);
        chk_eq("abort_fb_writes", fb_cnt, 6);
        end_checks(0, 0);

        // Reset in the middle of a ray request.
        do_reset();
        push_frame(3, H * V - 1);
        start_frame(3);
        k = 0;
        while (!(ray_valid && ray_x == X_W'(2)) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk_eq("midray_seen", int'(ray_valid), 1);
        do_reset();
        idle(5);
        chk_eq("post_rst_busy", int'(busy), 0);
        chk_eq("post_rst_ray_valid", int'(ray_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
